// File: rtl/alu_pkg.sv
// alu_pkg: FSM state encoding and op-bit field positions shared by the chunked ALU
package alu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int OP_W = 5;
  localparam int OP_R = 0;
  localparam int OP_S = 1;
  localparam int OP_NC = 2;
  localparam int OP_P = 3;
  localparam int OP_G = 4;
endpackage

// File: rtl/alu_chunked_if.sv
// alu_chunked_if: request/response bus (in_valid/in_ready/op/r/s/c_in, out_valid/out_ready/result/c_out/zero)
interface alu_chunked_if #(parameter int WIDTH = 8);
  import alu_pkg::*;
  logic in_valid, in_ready, c_in, out_valid, out_ready, c_out, zero;
  logic [OP_W-1:0] op;
  logic [WIDTH-1:0] r, s, result;
  modport master(output in_valid, op, r, s, c_in, out_ready, input in_ready, out_valid, result, c_out, zero);
  modport slave(input in_valid, op, r, s, c_in, out_ready, output in_ready, out_valid, result, c_out, zero);
endinterface

// File: rtl/alu_chunk.sv
// alu_chunk: combinational CHUNK-bit slice of the op-controlled ALU; ports op, r, s, c_in -> f, c_out
module alu_chunk
  import alu_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [OP_W-1:0]  op,
  input  logic [CHUNK-1:0] r,
  input  logic [CHUNK-1:0] s,
  input  logic             c_in,
  output logic [CHUNK-1:0] f,
  output logic             c_out
);
  always_comb begin
    logic c, x, y, g, p;
    c = c_in;
    x = 1'b0;
    y = 1'b0;
    g = 1'b0;
    p = 1'b0;
    f = '0;
    for (int i = 0; i < CHUNK; i++) begin
      x = r[i] ^ op[OP_R];
      y = s[i] ^ op[OP_S];
      g = x & y;
      p = x | y;
      f[i] = (g & ~op[OP_G]) ^ (p & ~op[OP_P]) ^ (~c & ~op[OP_NC]);
      c = g | (p & c);
    end
    c_out = c;
  end
endmodule

// File: rtl/alu_chunked.sv
// alu_chunked: multi-cycle ALU evaluating CHUNK bits per cycle; ports clk, rst_n, bus (slave side of alu_chunked_if)
module alu_chunked
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic clk,
  input logic rst_n,
  alu_chunked_if.slave bus
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [OP_W-1:0] op_q;
  logic [WIDTH-1:0] r_q, s_q, result_q, res_n;
  logic [CHUNK-1:0] f;
  logic carry, c_n, zero_q, last;
  assign last = idx == IW'(N - 1);
  alu_chunk #(.CHUNK(CHUNK)) u_chunk (
    .op(op_q),
    .r(r_q[idx*CHUNK +: CHUNK]),
    .s(s_q[idx*CHUNK +: CHUNK]),
    .c_in(carry),
    .f(f),
    .c_out(c_n)
  );
  always_comb begin
    res_n = result_q;
    res_n[idx*CHUNK +: CHUNK] = f;
    state_n = state == IDLE ? (bus.in_valid ? RUN : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : (bus.out_ready ? IDLE : DONE);
    // state sits at IDLE while reset is held, so ready is gated by rst_n directly
    bus.in_ready = rst_n && state == IDLE;
    bus.out_valid = state == DONE;
  end
  assign bus.result = result_q;
  assign bus.c_out = carry;
  assign bus.zero = zero_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      op_q <= '0;
      r_q <= '0;
      s_q <= '0;
      result_q <= '0;
      carry <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.in_valid) begin
        op_q <= bus.op;
        r_q <= bus.r;
        s_q <= bus.s;
        carry <= bus.c_in;
        idx <= '0;
      end else if (state == RUN) begin
        result_q <= res_n;
        carry <= c_n;
        zero_q <= res_n == '0;
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: doc/alu_chunked.md
ALU_CHUNKED -- requirements
Module: alu_chunked

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; SHALL be at least 1.
REQ-002 Parameter CHUNK, default 2: bits evaluated per cycle; SHALL be at least 1 and divide WIDTH exactly.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request holds a valid operation.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  5  control bits op[0]..op[4], per-bit function select.
REQ-008 r, s  input  WIDTH each  operands.
REQ-009 c_in  input  1  carry into bit 0.
REQ-010 out_valid  output  1  result, c_out and zero are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  computed word.
REQ-013 c_out  output  1  carry out of bit WIDTH-1.
REQ-014 zero  output  1  set when result equals 0.

Function
REQ-015 Per-bit function SHALL be, with carry-in c: x = r XOR op0; y = s XOR op1; g = x AND y; p = x OR y.
REQ-016 Per-bit carry-out SHALL be g OR (p AND c).
REQ-017 Per-bit output SHALL be (g AND NOT op4) XOR (p AND NOT op3) XOR (NOT c AND NOT op2).
REQ-018 Carry SHALL ripple from bit 0 upward; the carry into bit k+1 equals the carry-out of bit k.
REQ-019 Bit 0 of chunk 0 SHALL take c_in as its carry; each later chunk SHALL take the carry registered at the end of the previous chunk.
REQ-020 States: IDLE, RUN, DONE; in_ready is 1 only in IDLE; out_valid is 1 only in DONE.
REQ-021 IDLE with in_valid=1: SHALL capture op, r, s and c_in into internal registers, clear the chunk index, and go to RUN.
REQ-022 RUN: each cycle SHALL evaluate chunk[index] from captured values, write its CHUNK result bits, register its carry, and increment index.
REQ-023 RUN SHALL go to DONE after chunk WIDTH/CHUNK-1; latency from the accept edge to out_valid=1 is WIDTH/CHUNK cycles.
REQ-024 DONE SHALL hold result, c_out and zero stable until out_ready=1, then go to IDLE.
REQ-025 Input changes after the accept edge SHALL NOT affect the operation in flight.
REQ-026 zero SHALL be computed over the full WIDTH-bit result; it is valid only when out_valid=1.
REQ-027 CHUNK=WIDTH SHALL give single-cycle evaluation (latency 1); CHUNK=1 SHALL give bit-serial evaluation.
REQ-028 A new request SHALL NOT be accepted on the cycle DONE returns to IDLE; back-to-back throughput is one operation per WIDTH/CHUNK+2 cycles.

Reset
REQ-029 rst_n=0 SHALL asynchronously force the state to IDLE and clear result, c_out, zero, the chunk index, the carry register and the captured operands.
REQ-030 During reset: in_ready=0 and out_valid=0; in_ready rises in the first cycle after rst_n deasserts.
REQ-031 Reset asserted during RUN or DONE SHALL abandon the operation; no out_valid pulse follows.

Structure
REQ-032 State encoding and the op-bit field positions SHALL live in the shared package alu_pkg.
REQ-033 The per-bit function SHALL be a sub-module alu_chunk: CHUNK bits wide, combinational, with a carry-in and a carry-out; alu_chunked instantiates one and reuses it every cycle.

Verification
REQ-034 Test 1: WIDTH=8, CHUNK=2, op=00100, r=0xA5, s=0x0F -> out_valid after 4 cycles; result=0xAA; zero=0.
REQ-035 Test 2: op=00000, r=0xFF, s=0x01, c_in=0 -> result=0xFF (complement of the low byte of 0x100); c_out=1; this exercises carry across all chunks.
REQ-036 Test 3: op=11100, any operands -> result=0x00, zero=1.
REQ-037 Test 4: out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
REQ-038 Test 5: rst_n pulsed low mid-RUN -> immediate IDLE with all outputs 0; a following request gives the correct result.
REQ-039 Test 6: CHUNK in {1, 8} with the Test 2 vectors -> identical results, latencies 8 and 1.
